// File: rtl/bp_fe_fetch_queue.sv
// Registered multi-entry FIFO between pc_gen and the BE-facing FE queue port.
// Supports whole-queue flush and poisoning of the entry accepted in the previous cycle.
module bp_fe_fetch_queue #(
  parameter int entry_width_p       = 64,
  parameter int els_p               = 8,
  parameter int almost_full_slack_p = 2,
  localparam int lg_els_lp          = (els_p > 1) ? $clog2(els_p) : 1,
  localparam int count_width_lp     = $clog2(els_p + 1)
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic                      flush_i,
  input  logic                      poison_tail_i,
  input  logic [entry_width_p-1:0]  data_i,
  input  logic                      v_i,
  output logic                      ready_o,
  output logic [entry_width_p-1:0]  data_o,
  output logic                      v_o,
  input  logic                      ready_i,
  output logic [count_width_lp-1:0] count_o,
  output logic                      almost_full_o
);

  localparam logic [lg_els_lp-1:0]      last_idx_lp  = lg_els_lp'(els_p - 1);
  localparam logic [count_width_lp-1:0] els_cnt_lp   = count_width_lp'(els_p);
  localparam logic [count_width_lp-1:0] af_thresh_lp = count_width_lp'(els_p - almost_full_slack_p);
  localparam logic [count_width_lp-1:0] one_cnt_lp   = count_width_lp'(1);

  logic [entry_width_p-1:0]  mem_q [els_p];
  logic [lg_els_lp-1:0]      rd_ptr_q, rd_ptr_d;
  logic [lg_els_lp-1:0]      wr_ptr_q, wr_ptr_d;
  logic [count_width_lp-1:0] count_q, count_d;
  logic                      last_enq_v_q, last_enq_v_d;

  logic                 enq, deq, poison_eff;
  logic [lg_els_lp-1:0] wr_addr;

  // Explicit compare so non-power-of-two depths wrap correctly.
  function automatic logic [lg_els_lp-1:0] ptr_inc(input logic [lg_els_lp-1:0] p);
    return (p == last_idx_lp) ? '0 : p + lg_els_lp'(1);
  endfunction

  function automatic logic [lg_els_lp-1:0] ptr_dec(input logic [lg_els_lp-1:0] p);
    return (p == '0) ? last_idx_lp : p - lg_els_lp'(1);
  endfunction

  assign ready_o       = (count_q != els_cnt_lp) & ~flush_i;
  // A lone head that is being poisoned must never be handed to the BE.
  assign v_o           = (count_q != '0) & ~flush_i
                         & ~(poison_tail_i & last_enq_v_q & (count_q == one_cnt_lp));
  assign data_o        = mem_q[rd_ptr_q];
  assign count_o       = count_q;
  assign almost_full_o = (count_q >= af_thresh_lp);

  assign enq        = v_i & ready_o;
  assign deq        = v_o & ready_i;
  assign poison_eff = poison_tail_i & last_enq_v_q & ~flush_i;
  assign wr_addr    = poison_eff ? ptr_dec(wr_ptr_q) : wr_ptr_q;

  always_comb begin
    rd_ptr_d     = rd_ptr_q;
    wr_ptr_d     = wr_ptr_q;
    count_d      = count_q;
    last_enq_v_d = enq & ~flush_i;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (deq) rd_ptr_d = ptr_inc(rd_ptr_q);
      case ({poison_eff, enq})
        2'b01:   wr_ptr_d = ptr_inc(wr_ptr_q);
        2'b10:   wr_ptr_d = ptr_dec(wr_ptr_q);
        default: wr_ptr_d = wr_ptr_q;
      endcase
      count_d = count_q + count_width_lp'(enq) - count_width_lp'(deq)
                - count_width_lp'(poison_eff);
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      count_q      <= '0;
      last_enq_v_q <= 1'b0;
    end else begin
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      count_q      <= count_d;
      last_enq_v_q <= last_enq_v_d;
    end
  end

  // Storage carries no reset so it can map onto distributed/block RAM.
  always_ff @(posedge clk_i) begin
    if (enq) mem_q[wr_addr] <= data_i;
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      assert (!(enq && (count_q == els_cnt_lp)))
        else $error("enqueue while full");
      assert (count_q <= els_cnt_lp)
        else $error("occupancy above depth");
    end
  end
`endif

endmodule

// File: tb/tb_bp_fe_fetch_queue.sv
// Directed bench: depth-8 instance for fill/drain, poison, flush and reset; depth-5 for wrap.
module tb_bp_fe_fetch_queue;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // depth-8 instance
  logic        rst8, flush8, poison8, v_i8, ready_i8, ready_o8, v_o8, af8;
  logic [63:0] data_i8, data_o8;
  logic [3:0]  count8;

  // depth-5 instance
  logic        rst5, flush5, poison5, v_i5, ready_i5, ready_o5, v_o5, af5;
  logic [63:0] data_i5, data_o5;
  logic [2:0]  count5;

  bp_fe_fetch_queue #(.entry_width_p(64), .els_p(8), .almost_full_slack_p(2)) dut8 (
    .clk_i(clk), .reset_i(rst8), .flush_i(flush8), .poison_tail_i(poison8),
    .data_i(data_i8), .v_i(v_i8), .ready_o(ready_o8), .data_o(data_o8),
    .v_o(v_o8), .ready_i(ready_i8), .count_o(count8), .almost_full_o(af8));

  bp_fe_fetch_queue #(.entry_width_p(64), .els_p(5), .almost_full_slack_p(2)) dut5 (
    .clk_i(clk), .reset_i(rst5), .flush_i(flush5), .poison_tail_i(poison5),
    .data_i(data_i5), .v_i(v_i5), .ready_o(ready_o5), .data_o(data_o5),
    .v_o(v_o5), .ready_i(ready_i5), .count_o(count5), .almost_full_o(af5));

  // Apply one cycle of inputs to dut8 at the falling edge, then let outputs settle.
  task automatic cyc8(input logic v, input logic [63:0] d, input logic p,
                      input logic f, input logic r);
    @(negedge clk);
    v_i8 = v; data_i8 = d; poison8 = p; flush8 = f; ready_i8 = r;
    #1;
  endtask

  task automatic reset8();
    rst8 = 1'b1;
    v_i8 = 0; data_i8 = '0; poison8 = 0; flush8 = 0; ready_i8 = 0;
    @(posedge clk);
    @(negedge clk);
    rst8 = 1'b0;
  endtask

  task automatic test_reset();
    rst5 = 1'b1; v_i5 = 0; data_i5 = '0; poison5 = 0; flush5 = 0; ready_i5 = 0;
    reset8();
    rst8 = 1'b1;
    #1;
    n_checks++; if (v_o8 !== 1'b0) begin n_fail++; $display("FAIL reset_v_o: got %b want 0", v_o8); end
    n_checks++; if (ready_o8 !== 1'b1) begin n_fail++; $display("FAIL reset_ready_o: got %b want 1", ready_o8); end
    n_checks++; if (count8 !== 4'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", count8); end
    n_checks++; if (af8 !== 1'b0) begin n_fail++; $display("FAIL reset_af: got %b want 0", af8); end
    n_checks++; if (count5 !== 3'd0 || v_o5 !== 1'b0 || ready_o5 !== 1'b1) begin
      n_fail++; $display("FAIL reset_dut5: count %0d v_o %b ready_o %b want 0 0 1", count5, v_o5, ready_o5);
    end
    @(negedge clk);
    rst8 = 1'b0; rst5 = 1'b0;
    $display("test_reset done");
  endtask

  task automatic test_fill_drain();
    reset8();
    for (int i = 0; i < 8; i++) begin
      cyc8(1, 64'h10 + 64'(i), 0, 0, 0);
      n_checks++; if (ready_o8 !== 1'b1) begin n_fail++; $display("FAIL fill_ready[%0d]: got %b want 1", i, ready_o8); end
      n_checks++; if (count8 !== 4'(i)) begin n_fail++; $display("FAIL fill_count[%0d]: got %0d want %0d", i, count8, i); end
      n_checks++; if (af8 !== (i >= 6)) begin n_fail++; $display("FAIL fill_af[%0d]: got %b want %b", i, af8, (i >= 6)); end
      $display("fill enq %h count %0d", data_i8, count8);
    end
    // Full, with both v_i and ready_i asserted: dequeue only.
    for (int i = 0; i < 8; i++) begin
      cyc8(i == 0, 64'hEE, 0, 0, 1);
      n_checks++; if (ready_o8 !== (i != 0)) begin n_fail++; $display("FAIL drain_ready[%0d]: got %b want %b", i, ready_o8, (i != 0)); end
      n_checks++; if (v_o8 !== 1'b1) begin n_fail++; $display("FAIL drain_v_o[%0d]: got %b want 1", i, v_o8); end
      n_checks++; if (data_o8 !== 64'h10 + 64'(i)) begin n_fail++; $display("FAIL drain_data[%0d]: got %h want %h", i, data_o8, 64'h10 + 64'(i)); end
      n_checks++; if (count8 !== 4'(8 - i)) begin n_fail++; $display("FAIL drain_count[%0d]: got %0d want %0d", i, count8, 8 - i); end
      $display("drain deq %h count %0d", data_o8, count8);
    end
    cyc8(0, 0, 0, 0, 1);
    n_checks++; if (v_o8 !== 1'b0 || count8 !== 4'd0) begin n_fail++; $display("FAIL drain_empty: v_o %b count %0d want 0 0", v_o8, count8); end
  endtask

  task automatic test_wrap5();
    logic [63:0] exp_q[$];
    int sent = 0, got = 0;
    for (int c = 0; c < 200 && got < 20; c++) begin
      @(negedge clk);
      v_i5 = (sent < 20); data_i5 = 64'hA00 + 64'(sent); ready_i5 = ~c[0];
      poison5 = 0; flush5 = 0;
      #1;
      n_checks++; if (count5 !== 3'(exp_q.size())) begin n_fail++; $display("FAIL wrap_count c%0d: got %0d want %0d", c, count5, exp_q.size()); end
      n_checks++; if (count5 > 3'd5) begin n_fail++; $display("FAIL wrap_bound c%0d: got %0d want <=5", c, count5); end
      if (v_o5 && ready_i5) begin
        n_checks++;
        if (exp_q.size() == 0 || data_o5 !== exp_q[0]) begin
          n_fail++; $display("FAIL wrap_data #%0d: got %h want %h", got, data_o5, (exp_q.size() != 0) ? exp_q[0] : 64'hX);
        end
        $display("wrap deq %h", data_o5);
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        got++;
      end
      if (v_i5 && ready_o5) begin
        exp_q.push_back(data_i5);
        sent++;
      end
    end
    n_checks++; if (got != 20) begin n_fail++; $display("FAIL wrap_total: got %0d want 20", got); end
    @(negedge clk); v_i5 = 0; ready_i5 = 0;
  endtask

  task automatic test_tail_poison();
    reset8();
    cyc8(1, 64'hA, 0, 0, 0);
    cyc8(1, 64'hB, 0, 0, 0);
    cyc8(1, 64'hC, 1, 0, 0);
    n_checks++; if (v_o8 !== 1'b1 || data_o8 !== 64'hA) begin n_fail++; $display("FAIL tail_t2_head: v_o %b data %h want 1 a", v_o8, data_o8); end
    cyc8(0, 0, 0, 0, 1);
    n_checks++; if (count8 !== 4'd2) begin n_fail++; $display("FAIL tail_t3_count: got %0d want 2", count8); end
    n_checks++; if (data_o8 !== 64'hA) begin n_fail++; $display("FAIL tail_first: got %h want a", data_o8); end
    cyc8(0, 0, 0, 0, 1);
    n_checks++; if (v_o8 !== 1'b1 || data_o8 !== 64'hC) begin n_fail++; $display("FAIL tail_second: v_o %b data %h want 1 c", v_o8, data_o8); end
    cyc8(0, 0, 0, 0, 0);
    n_checks++; if (count8 !== 4'd0 || v_o8 !== 1'b0) begin n_fail++; $display("FAIL tail_empty: count %0d v_o %b want 0 0", count8, v_o8); end
  endtask

  task automatic test_head_poison();
    reset8();
    cyc8(1, 64'h99, 0, 0, 0);
    cyc8(0, 0, 1, 0, 1);
    n_checks++; if (v_o8 !== 1'b0) begin n_fail++; $display("FAIL head_mask: got %b want 0", v_o8); end
    n_checks++; if (count8 !== 4'd1) begin n_fail++; $display("FAIL head_t1_count: got %0d want 1", count8); end
    cyc8(0, 0, 1, 0, 1);
    n_checks++; if (count8 !== 4'd0 || v_o8 !== 1'b0) begin n_fail++; $display("FAIL head_t2: count %0d v_o %b want 0 0", count8, v_o8); end
    // Poison two cycles after the last enqueue must be ignored.
    cyc8(1, 64'h5A, 0, 0, 0);
    cyc8(0, 0, 0, 0, 0);
    cyc8(0, 0, 1, 0, 0);
    n_checks++; if (v_o8 !== 1'b1) begin n_fail++; $display("FAIL stale_poison_v_o: got %b want 1", v_o8); end
    cyc8(0, 0, 0, 0, 0);
    n_checks++; if (count8 !== 4'd1 || data_o8 !== 64'h5A) begin n_fail++; $display("FAIL stale_poison_keep: count %0d data %h want 1 5a", count8, data_o8); end
  endtask

  task automatic test_flush();
    reset8();
    for (int i = 0; i < 4; i++) cyc8(1, 64'h50 + 64'(i), 0, 0, 0);
    cyc8(1, 64'hEE, 1, 1, 1);
    n_checks++; if (ready_o8 !== 1'b0 || v_o8 !== 1'b0) begin n_fail++; $display("FAIL flush_outputs: ready_o %b v_o %b want 0 0", ready_o8, v_o8); end
    cyc8(1, 64'h77, 0, 0, 0);
    n_checks++; if (count8 !== 4'd0 || v_o8 !== 1'b0) begin n_fail++; $display("FAIL flush_cleared: count %0d v_o %b want 0 0", count8, v_o8); end
    cyc8(0, 0, 0, 0, 0);
    n_checks++; if (count8 !== 4'd1 || v_o8 !== 1'b1 || data_o8 !== 64'h77) begin
      n_fail++; $display("FAIL flush_after: count %0d v_o %b data %h want 1 1 77", count8, v_o8, data_o8);
    end
  endtask

  task automatic test_async_reset();
    reset8();
    for (int i = 0; i < 3; i++) cyc8(1, 64'h30 + 64'(i), 0, 0, 0);
    cyc8(0, 0, 0, 0, 0);
    n_checks++; if (count8 !== 4'd3) begin n_fail++; $display("FAIL areset_pre: got %0d want 3", count8); end
    #1 rst8 = 1'b1;
    #1;
    n_checks++; if (v_o8 !== 1'b0 || count8 !== 4'd0 || ready_o8 !== 1'b1) begin
      n_fail++; $display("FAIL areset_now: v_o %b count %0d ready_o %b want 0 0 1", v_o8, count8, ready_o8);
    end
    @(negedge clk);
    rst8 = 1'b0;
    cyc8(1, 64'h66, 0, 0, 0);
    cyc8(0, 0, 0, 0, 0);
    n_checks++; if (v_o8 !== 1'b1 || data_o8 !== 64'h66 || count8 !== 4'd1) begin
      n_fail++; $display("FAIL areset_after: v_o %b data %h count %0d want 1 66 1", v_o8, data_o8, count8);
    end
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_wrap5();
    test_tail_poison();
    test_head_poison();
    test_flush();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
